// File: rtl/bus_read_arbiter_pkg.sv
// Shared types and constants for the bus read arbiter.
package bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    RESP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_W_DEF = idx_w(2);

endpackage

// File: rtl/bus_read_arbiter_pick.sv
// Combinational winner selection among pending requesters.
// BUS_ARB_ROUND_ROBIN_EN switches from lowest-index priority to round robin.
module bus_arb_pick
  import bus_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
`ifdef BUS_ARB_ROUND_ROBIN_EN
  input  logic [GW-1:0]    last_grant,
`endif
  output logic [GW-1:0]    winner,
  output logic             any
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  int   idx;
  logic found;

  // Search starts just past the previous winner and wraps.
  always_comb begin
    winner = '0;
    any    = |req_valid;
    idx    = 0;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(last_grant) + 1 + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    any    = |req_valid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = GW'(i);
    end
  end
`endif

endmodule

// File: rtl/bus_read_arbiter.sv
// Shares one fixed-latency read port between N_REQ requesters.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module bus_read_arbiter
  import bus_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_address,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_W-1:0]             req_data,
  output logic [$clog2(N_REQ)-1:0]      grant,
  output logic                          busy,
  output logic                          bus_read_valid,
  input  logic                          bus_read_ready,
  output logic [ADDR_W-1:0]             bus_read_address,
  input  logic [DATA_W-1:0]             bus_read_data
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(READ_LATENCY + 1);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("bus_read_arbiter: READ_LATENCY must be >= 1");
  end
  if (N_REQ < 2) begin : g_bad_nreq
    $error("bus_read_arbiter: N_REQ must be >= 2");
  end

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [GW-1:0] winner;
  logic          any;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last_grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GW'(N_REQ - 1);
    end else if (state == IDLE && any) begin
      last_grant <= winner;
    end
  end

  bus_arb_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );
`else
  bus_arb_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .req_valid (req_valid),
    .winner    (winner),
    .any       (any)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      grant            <= '0;
      bus_read_address <= '0;
      req_data         <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any) begin
            grant            <= winner;
            bus_read_address <= req_address[winner];
          end
        end
        ADDR: begin
          if (bus_read_ready) cnt <= CW'(READ_LATENCY);
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // cnt==1 is the cycle the ROM word is on the bus.
          if (cnt == CW'(1)) req_data <= bus_read_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    bus_read_valid = 1'b0;
    req_ready      = '0;
    case (state)
      IDLE: begin
        if (any) state_n = ADDR;
      end
      ADDR: begin
        bus_read_valid = 1'b1;
        if (bus_read_ready) state_n = WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1)) state_n = RESP;
      end
      RESP: begin
        req_ready = N_REQ'(1) << grant;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
